if_stage: RTL and testbench

- Instruction-fetch stage of the mips_16b pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address and consumes the read word. Feeds the decode stage with instr_id/next_pc_id.
- Takes stall requests from the hazard unit and branch redirects from EX. Halts on a HALT encoding.

---
 rtl/mips_pkg.sv | 11 +
 rtl/if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM encoding, PC step and default NOP/HALT words for the mips_16b pipeline
package mips_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] NOP_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats hold, hold beats load, otherwise contents persist
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_hold,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_next_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_next_pc,
   output logic        o_valid
);
   // Capture a fetched word, inject a bubble, or keep the current contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_instr   <= NOP_INSTR;
         o_next_pc <= 32'd0;
         o_valid   <= 1'b0;
      end else if (i_flush) begin
         o_instr   <= NOP_INSTR;
         o_next_pc <= 32'd0;
         o_valid   <= 1'b0;
      end else if (!i_hold && i_load) begin
         o_instr   <= i_instr;
         o_next_pc <= i_next_pc;
         o_valid   <= 1'b1;
      end
   end
endmodule

// File: rtl/if_stage.sv
// if_stage: mips_16b instruction fetch (PC, fetch FSM, IF/ID); perf counters under IF_PERF_CNT_EN
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = NOP_DEFAULT,
   parameter logic [31:0] HALT_INSTR = HALT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic [31:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] next_pc_if,
   output logic [31:0] instr_if,
   output logic [31:0] instr_id,
   output logic [31:0] next_pc_id,
   output logic        valid_id,
   output logic        halted,
   output logic [31:0] fetch_count,
   output logic [31:0] redirect_count
);
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt, w_pc_inc;
   logic        w_redirect, w_fetch, w_flush, w_hold, w_load;

   assign w_pc_inc   = r_pc + PC_INC;
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign next_pc_if = w_pc_inc;
   assign instr_if   = imem_data;
   assign halted     = (r_state == S_HALT);
   // A redirect from EX is an older instruction, so it overrides stall and a wrong-path HALT
   assign w_redirect = clk_en && r_state != S_IDLE && br_taken;
   assign w_fetch    = clk_en && r_state == S_RUN && !br_taken && !stall;
   assign w_flush    = w_redirect || (clk_en && r_state == S_HALT && !stall);
   assign w_hold     = !clk_en || stall;
   assign w_load     = (r_state == S_RUN);

   // PC and fetch state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Next PC and state: IDLE spends one enabled edge before fetching; HALT keeps the PC
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (clk_en && r_state == S_IDLE) w_state_nxt = S_RUN;
      if (w_redirect) begin
         w_state_nxt = S_RUN;
         w_pc_nxt    = br_target;
      end else if (w_fetch) begin
         w_state_nxt = (imem_data == HALT_INSTR) ? S_HALT : S_RUN;
         w_pc_nxt    = (imem_data == HALT_INSTR) ? r_pc : w_pc_inc;
      end
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk       (clk),
      .reset     (reset),
      .i_hold    (w_hold),
      .i_flush   (w_flush),
      .i_load    (w_load),
      .i_instr   (imem_data),
      .i_next_pc (w_pc_inc),
      .o_instr   (instr_id),
      .o_next_pc (next_pc_id),
      .o_valid   (valid_id)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_count, r_redirect_count;
   // Fetch and redirect event counters, wrapping silently
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_count    <= 32'd0;
         r_redirect_count <= 32'd0;
      end else begin
         if (w_fetch) r_fetch_count <= r_fetch_count + 32'd1;
         if (w_redirect) r_redirect_count <= r_redirect_count + 32'd1;
      end
   end
   assign fetch_count    = r_fetch_count;
   assign redirect_count = r_redirect_count;
`else
   assign fetch_count    = 32'd0;
   assign redirect_count = 32'd0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a combinational imem model
module tb_if_stage;
   localparam logic [31:0] WORD = 32'h2001_0005;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b0;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic [31:0] halt_pc = 32'h1;
   logic [31:0] imem_data, imem_addr, pc, next_pc_if, instr_if, instr_id, next_pc_id;
   logic [31:0] fetch_count, redirect_count;
   logic        valid_id, halted;
   int          checks = 0;
   int          failures = 0;

   assign imem_data = (imem_addr == halt_pc) ? HALT : WORD;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .stall(stall),
      .br_taken(br_taken), .br_target(br_target), .imem_data(imem_data),
      .imem_addr(imem_addr), .pc(pc), .next_pc_if(next_pc_if), .instr_if(instr_if),
      .instr_id(instr_id), .next_pc_id(next_pc_id), .valid_id(valid_id), .halted(halted),
      .fetch_count(fetch_count), .redirect_count(redirect_count)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag, input int f, input int r);
      check({tag, "_fetch"}, fetch_count, PERF ? f : 0);
      check({tag, "_redir"}, redirect_count, PERF ? r : 0);
   endtask

   initial begin
      step();
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr_id, 32'h0);
      check("rst_npc", next_pc_id, 32'h0);
      check("rst_valid", {31'd0, valid_id}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check_cnt("rst", 0, 0);
      reset  = 1'b0;
      clk_en = 1'b1;
      step();
      check("idle_pc", pc, 32'h0);
      check("idle_valid", {31'd0, valid_id}, 32'd0);
      step();
      check("f1_pc", pc, 32'h4);
      check("f1_instr", instr_id, WORD);
      check("f1_npc", next_pc_id, 32'h4);
      check("f1_valid", {31'd0, valid_id}, 32'd1);
      check("f1_npc_if", next_pc_if, 32'h8);
      check("f1_instr_if", instr_if, WORD);
      step();
      check("f2_pc", pc, 32'h8);
      check("f2_npc", next_pc_id, 32'h8);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc", pc, 32'h8);
         check("stall_npc", next_pc_id, 32'h8);
         check("stall_valid", {31'd0, valid_id}, 32'd1);
      end
      stall = 1'b0;
      step();
      check("resume_pc", pc, 32'hC);
      check("resume_npc", next_pc_id, 32'hC);
      check_cnt("resume", 3, 0);
      br_taken  = 1'b1;
      br_target = 32'h40;
      stall     = 1'b1;
      step();
      check("br_pc", pc, 32'h40);
      check("br_instr", instr_id, 32'h0);
      check("br_npc", next_pc_id, 32'h0);
      check("br_valid", {31'd0, valid_id}, 32'd0);
      check_cnt("br", 3, 1);
      stall     = 1'b0;
      br_target = 32'h10;
      step();
      br_taken = 1'b0;
      halt_pc  = 32'h10;
      check("br16_pc", pc, 32'h10);
      step();
      check("halt_instr", instr_id, HALT);
      check("halt_npc", next_pc_id, 32'h14);
      check("halt_valid", {31'd0, valid_id}, 32'd1);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, 32'h10);
      check_cnt("halt", 4, 2);
      stall = 1'b1;
      step();
      check("halt_stall_instr", instr_id, HALT);
      check("halt_stall_valid", {31'd0, valid_id}, 32'd1);
      stall = 1'b0;
      step();
      check("halt_bub_valid", {31'd0, valid_id}, 32'd0);
      check("halt_bub_instr", instr_id, 32'h0);
      check("halt_hold_pc", pc, 32'h10);
      check("halt_sticky", {31'd0, halted}, 32'd1);
      br_taken  = 1'b1;
      br_target = 32'h80;
      step();
      br_taken = 1'b0;
      halt_pc  = 32'h1;
      check("unhalt_pc", pc, 32'h80);
      check("unhalt_flag", {31'd0, halted}, 32'd0);
      check_cnt("unhalt", 4, 3);
      step();
      check("run84_pc", pc, 32'h84);
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("frz_pc", pc, 32'h84);
         check("frz_instr", instr_id, WORD);
         check("frz_npc", next_pc_id, 32'h84);
         check("frz_valid", {31'd0, valid_id}, 32'd1);
         check_cnt("frz", 5, 3);
      end
      clk_en    = 1'b1;
      br_taken  = 1'b1;
      br_target = 32'hFFFF_FFFC;
      step();
      br_taken = 1'b0;
      check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      check("wrap_npc_if", next_pc_if, 32'h0);
      step();
      check("wrap_pc", pc, 32'h0);
      check("wrap_npc", next_pc_id, 32'h0);
      check("wrap_valid", {31'd0, valid_id}, 32'd1);
      check_cnt("wrap", 6, 4);
      halt_pc = 32'h0;
      step();
      check("halt2_flag", {31'd0, halted}, 32'd1);
      check("halt2_npc", next_pc_id, 32'h4);
      #3 reset = 1'b1;
      #1;
      check("arst_pc", pc, 32'h0);
      check("arst_halted", {31'd0, halted}, 32'd0);
      check("arst_valid", {31'd0, valid_id}, 32'd0);
      check("arst_instr", instr_id, 32'h0);
      check("arst_npc", next_pc_id, 32'h0);
      check_cnt("arst", 0, 0);
      reset = 1'b0;
      step();
      check("restart_pc", pc, 32'h0);
      check("restart_halted", {31'd0, halted}, 32'd0);
      check("restart_valid", {31'd0, valid_id}, 32'd0);
      step();
      check("restart_halt", {31'd0, halted}, 32'd1);
      check("restart_instr", instr_id, HALT);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
